fade_sequencer: RTL and testbench
=================================

Name: fade_sequencer

Overview:
- Sequences one shared fade engine (prescaler plus up/down gain counter) on behalf of NUM_REQ effect requesters, e.g. the user fade button and the auto-fade trigger.
- Round-robin arbitration; a grant handshake latches each winner's command (mode, step interval).
- Runs fade-out, fade-in or fade-out-then-in legs and emits a GAIN_BITS-wide gain word to the audio multiplier.

Parameters:
- NUM_REQ, 2, number of requesters.
- GAIN_BITS, 8, gain word width; GAIN_MAX = 2^GAIN_BITS-1.
- STEP_BITS, 22, width of the per-request step interval and the prescaler.

Ports:
- clk  in  1  system clock.
- n_reset  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request; held high until granted.
- req_mode  in  2*NUM_REQ  2 bits per requester: 00 NOP, 01 FADE_OUT, 10 FADE_IN, 11 FADE_OUT_IN.
- req_step  in  STEP_BITS*NUM_REQ  per-requester step interval L; gain steps once every L+1 clocks.
- abort  in  1  ends the active fade.
- grant  out  NUM_REQ  one-hot, 1-cycle grant pulse.
- busy  out  1  high whenever state != IDLE.
- done  out  1  1-cycle completion pulse.
- gain  out  GAIN_BITS  current gain; GAIN_MAX = unity.

Behaviour:
- Reset (asynchronous, active-low): state IDLE, gain = GAIN_MAX, grant = 0, done = 0, busy = 0, prescaler = 0, round-robin pointer = requester 0.
- States: IDLE, GRANT, DOWN, UP, DONE.
- IDLE: if any req is high, the arbiter picks the winner and next state is GRANT. The pointer starts at the last granted index + 1 (index 0 after reset).
- GRANT (1 cycle): grant[winner] = 1; the winner's mode and step are latched; prescaler cleared.
  - Next state: DOWN for 01 or 11, UP for 10, DONE for 00.
  - The requester must drop req in the cycle after seeing grant. A req still high is treated as a new request.
- DOWN:
  - If gain == 0: next state is UP for mode 11, otherwise DONE.
  - Else: prescaler increments. When prescaler == L, prescaler clears and gain decrements by 1 in that same cycle.
- UP: same as DOWN, but increments toward GAIN_MAX. If gain == GAIN_MAX, next state is DONE.
- Legs start from the current gain, not a reloaded value. Fade-in from gain 255 therefore finishes with zero steps: GRANT, then UP for 1 cycle, then DONE.
- Prescaler clears on every leg entry (DOWN->UP included).
- gain never wraps. Decrement at 0 and increment at GAIN_MAX are impossible by construction.
- DONE (1 cycle): done = 1; next state IDLE. gain holds its final value.
- abort:
  - In DOWN or UP: next state DONE, gain frozen at its current value, prescaler cleared. abort beats a same-cycle gain step; no step is applied.
  - Ignored in IDLE, GRANT and DONE.
- Duration with Δ = |start gain - target|: a leg occupies Δ*(L+1)+1 cycles in DOWN/UP.
- Requests arriving while busy wait and are arbitrated on return to IDLE.
- Reset mid-fade: immediate return to reset values; gain snaps to GAIN_MAX.

Optional Feature:
- Macro FADE_PAUSE_EN.
- Defined: adds input port pause (1 bit). While pause = 1 in DOWN or UP, prescaler and gain hold, and state holds unless abort is also high. abort takes precedence over pause.
- Undefined: no pause port; behaviour exactly as above.

Decomposition:
- Package fade_pkg holds:
  - fade_mode_t enum (NOP, FADE_OUT, FADE_IN, FADE_OUT_IN).
  - fade_state_t enum (IDLE, GRANT, DOWN, UP, DONE).
  - localparam helper for GAIN_MAX.
- Sub-module fade_rr_arbiter: NUM_REQ round-robin arbiter taking req, pointer and an update strobe. It outputs the one-hot winner and winner index.
- Counters and FSM stay in fade_sequencer.

Test Plan:
- Reset, then req0 with mode 01, L=0 -> grant[0] pulses 1 cycle after req. gain steps 255->0 one per cycle over 255 cycles. done pulses 1 cycle after gain==0 is seen. busy drops with done.
- req1 with mode 10, L=3, from gain 0 -> gain increments every 4th cycle. Reaches 255 after 1020 cycles in UP, then done.
- req0 and req1 asserted together after reset -> req0 granted first. req1 granted in the GRANT cycle of the next arbitration. A subsequent simultaneous pair grants req0 (pointer rotation).
- Mode 11, L=1 from gain 255 -> 255 to 0 in 510 cycles, 1 cycle at 0, then climb back to 255; single done at end.
- abort at gain 100 during DOWN (same cycle as a due step) -> gain stays 100, done next cycle, then IDLE. Mode 00 request -> GRANT then DONE, gain unchanged.
- n_reset asserted mid-fade at gain 40 -> gain = 255, busy = 0, grant = 0 asynchronously. With FADE_PAUSE_EN, pause held 10 cycles mid-leg -> gain and prescaler frozen, leg extends by exactly 10 cycles.

Source files
------------

// File: rtl/fade_pkg.sv
// Shared types for the fade sequencer: requester modes, FSM states and the gain ceiling helper.
package fade_pkg;

    typedef enum logic [1:0] {
        NOP         = 2'b00,
        FADE_OUT    = 2'b01,
        FADE_IN     = 2'b10,
        FADE_OUT_IN = 2'b11
    } fade_mode_t;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        DOWN,
        UP,
        DONE
    } fade_state_t;

    localparam int unsigned GAIN_BITS_DEFAULT = 8;

    // Unity gain for a given gain word width (all ones).
    function automatic int unsigned gain_max_of(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/fade_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr and reports the first active request.
module fade_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               update,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               found
);

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (update && !found && req[(int'(ptr) + i) % NUM_REQ]) begin
                found                                 = 1'b1;
                winner[(int'(ptr) + i) % NUM_REQ]     = 1'b1;
                winner_idx                            = IDX_W'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/fade_sequencer.sv
// Shared fade engine sequenced on behalf of NUM_REQ requesters with round-robin grants.
// Optional FADE_PAUSE_EN adds a pause input that freezes the active leg.
module fade_sequencer
    import fade_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int GAIN_BITS = 8,
    parameter int STEP_BITS = 22
) (
    input  logic                         clk,
    input  logic                         n_reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [2*NUM_REQ-1:0]         req_mode,
    input  logic [STEP_BITS*NUM_REQ-1:0] req_step,
    input  logic                         abort,
`ifdef FADE_PAUSE_EN
    input  logic                         pause,
`endif
    output logic [NUM_REQ-1:0]           grant,
    output logic                         busy,
    output logic                         done,
    output logic [GAIN_BITS-1:0]         gain
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [GAIN_BITS-1:0] GAIN_MAX = GAIN_BITS'(gain_max_of(GAIN_BITS));

    fade_state_t          state, state_nxt;
    logic [GAIN_BITS-1:0] gain_nxt;
    logic [STEP_BITS-1:0] presc, presc_nxt;
    logic [IDX_W-1:0]     ptr, ptr_nxt;
    logic [IDX_W-1:0]     widx_q;
    logic [NUM_REQ-1:0]   onehot_q;
    fade_mode_t           mode_q, cur_mode;
    logic [STEP_BITS-1:0] step_q;
    logic [NUM_REQ-1:0]   arb_winner;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_found;
    logic                 pause_act;

`ifdef FADE_PAUSE_EN
    assign pause_act = pause;
`else
    assign pause_act = 1'b0;
`endif

    fade_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req),
        .ptr        (ptr),
        .update     (state == IDLE),
        .winner     (arb_winner),
        .winner_idx (arb_idx),
        .found      (arb_found)
    );

    assign ptr_nxt  = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
    // The winner still holds its command during GRANT, so read it live to pick the first leg.
    assign cur_mode = fade_mode_t'(req_mode[2*widx_q +: 2]);

    assign grant = (state == GRANT) ? onehot_q : '0;
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);

    always_comb begin
        state_nxt = state;
        gain_nxt  = gain;
        presc_nxt = presc;
        case (state)
            IDLE: begin
                if (arb_found) state_nxt = GRANT;
            end
            GRANT: begin
                presc_nxt = '0;
                case (cur_mode)
                    FADE_OUT, FADE_OUT_IN: state_nxt = DOWN;
                    FADE_IN:               state_nxt = UP;
                    default:               state_nxt = DONE;
                endcase
            end
            DOWN: begin
                if (abort) begin
                    state_nxt = DONE;
                    presc_nxt = '0;
                end else if (pause_act) begin
                    state_nxt = DOWN;
                end else if (gain == '0) begin
                    state_nxt = (mode_q == FADE_OUT_IN) ? UP : DONE;
                    presc_nxt = '0;
                end else if (presc == step_q) begin
                    presc_nxt = '0;
                    gain_nxt  = gain - 1'b1;
                end else begin
                    presc_nxt = presc + 1'b1;
                end
            end
            UP: begin
                if (abort) begin
                    state_nxt = DONE;
                    presc_nxt = '0;
                end else if (pause_act) begin
                    state_nxt = UP;
                end else if (gain == GAIN_MAX) begin
                    state_nxt = DONE;
                    presc_nxt = '0;
                end else if (presc == step_q) begin
                    presc_nxt = '0;
                    gain_nxt  = gain + 1'b1;
                end else begin
                    presc_nxt = presc + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
            gain  <= GAIN_MAX;
            presc <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            gain  <= gain_nxt;
            presc <= presc_nxt;
            if (arb_found) ptr <= ptr_nxt;
        end
    end

    // Command capture: only meaningful once a grant has been issued, so no reset needed.
    always_ff @(posedge clk) begin
        if (arb_found) begin
            widx_q   <= arb_idx;
            onehot_q <= arb_winner;
        end
        if (state == GRANT) begin
            mode_q <= cur_mode;
            step_q <= req_step[STEP_BITS*widx_q +: STEP_BITS];
        end
    end

endmodule

// File: tb/tb_fade_sequencer.sv
// Scoreboard bench for fade_sequencer: stimulus queues expected grant/done events, a monitor checks them.
module tb_fade_sequencer;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [1:0]  req;
    logic [3:0]  req_mode;
    logic [43:0] req_step;
    logic        abort;
    logic        pause;
    logic [1:0]  grant;
    logic        busy;
    logic        done;
    logic [7:0]  gain;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int last_grant_cyc = 0;

    typedef struct {
        bit         is_done;
        logic [1:0] grant_exp;
        int         gain_exp;
        int         dur_exp;
        string      name;
    } exp_t;

    exp_t sbq[$];

    fade_sequencer #(
        .NUM_REQ   (2),
        .GAIN_BITS (8),
        .STEP_BITS (22)
    ) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .req      (req),
        .req_mode (req_mode),
        .req_step (req_step),
        .abort    (abort),
`ifdef FADE_PAUSE_EN
        .pause    (pause),
`endif
        .grant    (grant),
        .busy     (busy),
        .done     (done),
        .gain     (gain)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitor: pops the next expected event whenever the DUT presents a grant or done pulse.
    always @(negedge clk) begin
        if (n_reset && (grant != 2'b00 || done)) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: grant=%0d done=%0d with empty scoreboard", grant, done);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check({e.name, "_kind"}, int'(done), int'(e.is_done));
                if (e.is_done && done) begin
                    check({e.name, "_gain"}, int'(gain), e.gain_exp);
                    check({e.name, "_dur"}, cyc - last_grant_cyc, e.dur_exp);
                end else if (!e.is_done && !done) begin
                    check({e.name, "_onehot"}, int'(grant), int'(e.grant_exp));
                    last_grant_cyc = cyc;
                end
            end
        end
    end

    task automatic push_grant(input int i, input string nm);
        exp_t e;
        e.is_done = 1'b0; e.grant_exp = 2'(1 << i); e.gain_exp = 0; e.dur_exp = 0;
        e.name = {nm, "_grant"};
        sbq.push_back(e);
    endtask

    task automatic expect_session(input int i, input int gain_e, input int dur_e, input string nm);
        exp_t e;
        push_grant(i, nm);
        e.is_done = 1'b1; e.grant_exp = 2'b00; e.gain_exp = gain_e; e.dur_exp = dur_e;
        e.name = {nm, "_done"};
        sbq.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [1:0] m, input int l);
        req_mode[2*i +: 2]   = m;
        req_step[22*i +: 22] = 22'(l);
        req[i]               = 1'b1;
    endtask

    task automatic wait_grant(output int gcyc);
        bit seen = 1'b0;
        gcyc = -1;
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(negedge clk);
            if (grant != 2'b00) begin
                seen = 1'b1;
                gcyc = cyc;
                req  = req & ~grant;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: got none expected a grant within 3000 cycles");
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int n = 0; n < 3000 && !idle; n++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still %0d expected 0", busy);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, g, g1, cur_g;
        n_reset = 1'b0; req = '0; req_mode = '0; req_step = '0; abort = 1'b0; pause = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_gain", int'(gain), 255);
        check("reset_busy", int'(busy), 0);
        check("reset_grant", int'(grant), 0);
        check("reset_done", int'(done), 0);
        n_reset = 1'b1;
        @(negedge clk);

        // Simultaneous pair after reset: req0 fades out at L=0, req1 then fades in at L=3.
        expect_session(0, 0, 257, "out_l0");
        expect_session(1, 255, 1022, "in_l3");
        set_req(0, 2'b01, 0);
        set_req(1, 2'b10, 3);
        c = cyc;
        wait_grant(g);
        check("grant0_latency", g - c, 1);
        wait_cyc(g + 1);   check("out_l0_gain_start", int'(gain), 255);
        wait_cyc(g + 101); check("out_l0_gain_mid", int'(gain), 155);
        wait_cyc(g + 256); check("out_l0_gain_zero", int'(gain), 0);
        wait_grant(g1);
        check("grant1_gap", g1 - g, 259);
        wait_cyc(g1 + 41); check("in_l3_gain_41", int'(gain), 10);
        wait_cyc(g1 + 44); check("in_l3_gain_44", int'(gain), 10);
        wait_cyc(g1 + 45); check("in_l3_gain_45", int'(gain), 11);
        wait_idle();

        // Second pair: pointer has rotated back to 0; fade-in from unity takes zero steps.
        expect_session(0, 255, 1023, "outin_l1");
        expect_session(1, 255, 2, "in_from_max");
        set_req(0, 2'b11, 1);
        set_req(1, 2'b10, 0);
        c = cyc;
        wait_grant(g);
        check("pair2_latency", g - c, 1);
        wait_cyc(g + 511); check("outin_bottom", int'(gain), 0);
        wait_cyc(g + 513); check("outin_up_first", int'(gain), 0);
        wait_cyc(g + 514); check("outin_up_step", int'(gain), 1);
        wait_grant(g1);
        check("pair2_grant1_gap", g1 - g, 1025);
        wait_idle();

        // Abort on the cycle a step is due at gain 100.
        expect_session(0, 100, 313, "abort");
        set_req(0, 2'b01, 1);
        wait_grant(g);
        wait_cyc(g + 311); check("abort_pre_gain", int'(gain), 100);
        wait_cyc(g + 312);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_hold_gain", int'(gain), 100);
        wait_idle();

        expect_session(1, 100, 1, "nop");
        set_req(1, 2'b00, 5);
        wait_grant(g);
        wait_idle();
        check("nop_gain", int'(gain), 100);
        cur_g = 100;

`ifdef FADE_PAUSE_EN
        expect_session(0, 255, 167, "pause");
        set_req(0, 2'b10, 0);
        wait_grant(g);
        wait_cyc(g + 21);
        pause = 1'b1;
        check("pause_gain_enter", int'(gain), 120);
        wait_cyc(g + 31);
        pause = 1'b0;
        check("pause_gain_held", int'(gain), 120);
        wait_cyc(g + 32); check("pause_gain_resume", int'(gain), 121);
        wait_idle();
        cur_g = 255;
`endif

        // Asynchronous reset mid-fade at gain 40.
        push_grant(0, "reset_mid");
        set_req(0, 2'b01, 0);
        wait_grant(g);
        wait_cyc(g + 1 + cur_g - 40);
        check("reset_mid_gain40", int'(gain), 40);
        #2 n_reset = 1'b0;
        #1;
        check("async_reset_gain", int'(gain), 255);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_grant", int'(grant), 0);
        check("async_reset_done", int'(done), 0);
        req = '0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);

        // Pointer must be back at 0 after reset.
        expect_session(0, 0, 257, "post_reset_out");
        expect_session(1, 0, 1, "post_reset_nop");
        set_req(0, 2'b01, 0);
        set_req(1, 2'b00, 0);
        wait_grant(g);
        wait_grant(g1);
        wait_idle();

        repeat (2) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
